// File: rtl/oversampler_mc.sv
// Multichannel oversampler. An internal divider strobes a capture every SAMPLE_COUNT cycles.
// Each channel sums 2^RATIO_LOG2 captures per block. The block sum is shifted down to
// OUT_WIDTH bits, which keeps EXTRA_BITS of added resolution, with optional round-half-up.
module oversampler_mc #(
  parameter int unsigned IN_WIDTH     = 12,
  parameter int unsigned N_CHANNELS   = 2,
  parameter int unsigned RATIO_LOG2   = 3,
  parameter int unsigned EXTRA_BITS   = 1,
  parameter int unsigned SAMPLE_COUNT = 128
) (
  input  logic                                      clk_100mhz,
  input  logic                                      rst_n,
  input  logic                                      enable,
  input  logic                                      round_en,
  input  logic [N_CHANNELS*IN_WIDTH-1:0]            data_in,
  output logic [N_CHANNELS*(IN_WIDTH+EXTRA_BITS)-1:0] data_out,
  output logic                                      data_valid,
  output logic                                      sample_trigger
);

  localparam int unsigned OutWidth = IN_WIDTH + EXTRA_BITS;
  localparam int unsigned Shift    = RATIO_LOG2 - EXTRA_BITS;
  localparam int unsigned AccWidth = IN_WIDTH + RATIO_LOG2;
  localparam int unsigned DivWidth = $clog2(SAMPLE_COUNT);

  localparam logic [DivWidth-1:0]   DivMax    = DivWidth'(SAMPLE_COUNT - 1);
  localparam logic [RATIO_LOG2-1:0] CntMax    = {RATIO_LOG2{1'b1}};
  // Half an output LSB. This is zero when Shift is 0, so rounding then has no effect.
  localparam logic [AccWidth:0]     RoundHalf = (AccWidth + 1)'((1 << Shift) >> 1);

  logic [DivWidth-1:0]                    div_q, div_d;
  logic [RATIO_LOG2-1:0]                  cnt_q, cnt_d;
  logic [N_CHANNELS-1:0][AccWidth-1:0]    acc_q, acc_d;
  logic [N_CHANNELS-1:0][OutWidth-1:0]    dout_q, dout_d;
  logic                                   trig_q, trig_d;
  logic                                   valid_q, valid_d;

  logic [N_CHANNELS-1:0][AccWidth:0]      sum_c;
  logic [N_CHANNELS-1:0][AccWidth:0]      sum_shr;
  logic [N_CHANNELS-1:0][OutWidth-1:0]    block_res;
  logic                                   unused_hi;

  // Final sum of the block, including the current sample. This value is only used on the
  // last strobe of a block.
  always_comb begin
    unused_hi = 1'b0;
    for (int ch = 0; ch < int'(N_CHANNELS); ch++) begin
      sum_c[ch]     = {1'b0, acc_q[ch]}
                    + (AccWidth + 1)'(data_in[ch*IN_WIDTH +: IN_WIDTH])
                    + (round_en ? RoundHalf : '0);
      sum_shr[ch]   = sum_c[ch] >> Shift;
      block_res[ch] = sum_shr[ch][OutWidth-1:0];
      // These upper bits are always zero because the result fits in OutWidth.
      unused_hi     = unused_hi ^ (^sum_shr[ch][AccWidth:OutWidth]);
    end
  end

  // Next-state logic for the divider, the sample counter, the accumulators and the outputs.
  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    trig_d  = 1'b0;
    valid_d = 1'b0;
    if (!enable) begin
      // Halt and discard any partial block. data_out keeps its last value.
      div_d = '0;
      cnt_d = '0;
      acc_d = '0;
    end else begin
      if (div_q == DivMax) begin
        div_d  = '0;
        trig_d = 1'b1;
      end else begin
        div_d = div_q + DivWidth'(1);
      end
      if (trig_q) begin
        if (cnt_q == CntMax) begin
          dout_d  = block_res;
          acc_d   = '0;
          cnt_d   = '0;
          valid_d = 1'b1;
        end else begin
          for (int ch = 0; ch < int'(N_CHANNELS); ch++) begin
            acc_d[ch] = acc_q[ch] + AccWidth'(data_in[ch*IN_WIDTH +: IN_WIDTH]);
          end
          cnt_d = cnt_q + RATIO_LOG2'(1);
        end
      end
    end
  end

  // State registers. Reset is asynchronous and clears everything, including data_out.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      trig_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      trig_q  <= trig_d;
      valid_q <= valid_d;
    end
  end

  assign data_out       = dout_q;
  assign data_valid     = valid_q;
  assign sample_trigger = trig_q;

endmodule
